// File: rtl/fp_pkg.sv
// fp_pkg: shared state/class types and special-value constants for the FP ALU units
package fp_pkg;
   typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_NORM, S_DONE} fp_div_state_t;
   typedef enum logic [1:0] {CLS_ZERO, CLS_NORMAL, CLS_INF, CLS_NAN} fp_class_t;
   function automatic logic [63:0] fp_qnan(input int m, input int e);
      return (((64'd1 << e) - 64'd1) << m) | (64'd1 << (m - 1));
   endfunction
   function automatic logic [63:0] fp_inf_mag(input int m, input int e);
      return ((64'd1 << e) - 64'd1) << m;
   endfunction
endpackage

// File: rtl/fp_classify.sv
// fp_classify: splits an operand magnitude into its class and hidden-bit mantissa
module fp_classify
   import fp_pkg::*;
#(
   parameter int M = 23,
   parameter int E = 8
)(
   input  logic [M+E-1:0] mag,
   output fp_class_t      cls,
   output logic [M:0]     mant
);
   logic [E-1:0] exp_f;
   logic [M-1:0] frac;
   assign exp_f = mag[M+E-1:M];
   assign frac  = mag[M-1:0];
   assign mant  = {1'b1, frac};
   // exponent 0 flushes to zero; all-ones splits inf from NaN on the fraction
   always_comb
      cls = (exp_f == '0) ? CLS_ZERO : (exp_f != '1) ? CLS_NORMAL : (frac == '0) ? CLS_INF : CLS_NAN;
endmodule

// File: rtl/fp_div.sv
// fp_div: sequential restoring FP divider; define FP_DIV_ROUND_EN for round-to-nearest-even
module fp_div
   import fp_pkg::*;
#(
   parameter int                       Mantissa_Size = 23,
   parameter int                       Exponent_Size = 8,
   parameter logic [Exponent_Size-1:0] Bias          = Exponent_Size'(127)
)(
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enable,
   input  logic                                load,
   input  logic [Mantissa_Size+Exponent_Size:0] A,
   input  logic [Mantissa_Size+Exponent_Size:0] B,
   output logic [Mantissa_Size+Exponent_Size:0] result,
   output logic                                done,
   output logic                                zero,
   output logic                                overflow,
   output logic                                underflow,
   output logic                                NAN,
   output logic                                div_by_zero
);
   localparam int M  = Mantissa_Size;
   localparam int E  = Exponent_Size;
   localparam int W  = M + E + 1;
   localparam int EW = E + 2;
   localparam int Q  = M + 3;
   localparam int CW = $clog2(Q);
   localparam logic [W-1:0]         QNAN    = W'(fp_qnan(M, E));
   localparam logic [W-2:0]         INF_MAG = (W-1)'(fp_inf_mag(M, E));
   localparam logic signed [EW-1:0] EMAX    = EW'((1 << E) - 1);

   fp_div_state_t state, state_n;
   fp_class_t ca, cb;
   logic [M:0] mant_a, mant_b, mb;
   logic [M+1:0] rem, rem_sub;
   logic [Q-1:0] q;
   logic [CW-1:0] cnt;
   logic sign, s_in;
   logic signed [EW-1:0] e0, e0_in, e_n, e_r;
   logic [W-1:0] sp_res, sp_res_in, n_res;
   logic [4:0] flags, sp_flags, sp_flags_in, n_flags;
   logic is_nan, dbz, inf_r, special, ge, q_int, rnd, carry, ovf, unf;
   logic [M-1:0] frac, frac_r;

   fp_classify #(.M(M), .E(E)) u_cls_a (.mag(A[W-2:0]), .cls(ca), .mant(mant_a));
   fp_classify #(.M(M), .E(E)) u_cls_b (.mag(B[W-2:0]), .cls(cb), .mant(mant_b));

   assign s_in        = A[W-1] ^ B[W-1];
   assign is_nan      = (ca == CLS_NAN) | (cb == CLS_NAN) | ((ca == CLS_INF) & (cb == CLS_INF)) |
                        ((ca == CLS_ZERO) & (cb == CLS_ZERO));
   assign dbz         = (ca == CLS_NORMAL) & (cb == CLS_ZERO);
   assign inf_r       = ca == CLS_INF;
   assign special     = !((ca == CLS_NORMAL) && (cb == CLS_NORMAL));
   assign sp_res_in   = is_nan ? QNAN : (dbz | inf_r) ? {s_in, INF_MAG} : {s_in, {(W-1){1'b0}}};
   assign sp_flags_in = {!is_nan & !dbz & !inf_r, 2'b00, is_nan, dbz};
   assign e0_in       = {2'b00, A[W-2:M]} - {2'b00, B[W-2:M]} + {2'b00, Bias};

   assign ge      = rem >= {1'b0, mb};
   assign rem_sub = rem - (ge ? {1'b0, mb} : '0);

   // a quotient below 1.0 is shifted left one place and the exponent drops by one
   assign q_int = q[Q-1];
   assign frac  = q_int ? q[Q-2:2] : q[Q-3:1];
   assign e_n   = e0 - (q_int ? EW'(0) : EW'(1));
`ifdef FP_DIV_ROUND_EN
   logic guard, sticky;
   assign guard  = q_int ? q[1] : q[0];
   assign sticky = (q_int & q[0]) | (rem != '0);
   assign rnd    = guard & (sticky | frac[0]);
`else
   assign rnd = 1'b0;
`endif
   assign {carry, frac_r} = {1'b0, frac} + {{M{1'b0}}, rnd};
   assign e_r     = e_n + {{(EW-1){1'b0}}, carry};
   assign unf     = e_n[EW-1] | (e_n == '0);
   assign ovf     = !unf & (e_r >= EMAX);
   assign n_res   = unf ? {sign, {(W-1){1'b0}}} : ovf ? {sign, INF_MAG} : {sign, e_r[E-1:0], frac_r};
   assign n_flags = {unf, ovf, unf, 2'b00};

   assign {zero, overflow, underflow, NAN, div_by_zero} = flags;

   // next state: load restarts from any state, otherwise DIVIDE -> NORM -> DONE
   always_comb begin
      state_n = state;
      if (load)
         state_n = special ? S_DONE : S_DIVIDE;
      else if (state == S_DIVIDE)
         state_n = (cnt == CW'(Q - 1)) ? S_NORM : S_DIVIDE;
      else if (state == S_NORM)
         state_n = S_DONE;
   end

   // state register, frozen while enable is low
   always_ff @(posedge clk)
      if (rst)
         state <= S_IDLE;
      else if (enable)
         state <= state_n;

   // operand capture, one restoring step per DIVIDE cycle, and output publishing
   always_ff @(posedge clk)
      if (rst) begin
         mb       <= '0;
         rem      <= '0;
         q        <= '0;
         cnt      <= '0;
         sign     <= 1'b0;
         e0       <= '0;
         sp_res   <= '0;
         sp_flags <= '0;
         result   <= '0;
         flags    <= '0;
         done     <= 1'b0;
      end else if (enable) begin
         if (load) begin
            mb       <= mant_b;
            rem      <= {1'b0, mant_a};
            q        <= '0;
            cnt      <= '0;
            sign     <= s_in;
            e0       <= e0_in;
            sp_res   <= sp_res_in;
            sp_flags <= sp_flags_in;
            done     <= 1'b0;
         end else if (state == S_DIVIDE) begin
            rem <= {rem_sub[M:0], 1'b0};
            q   <= {q[Q-2:0], ge};
            cnt <= cnt + 1'b1;
         end else if (state == S_NORM) begin
            result <= n_res;
            flags  <= n_flags;
            done   <= 1'b1;
         end else if ((state == S_DONE) && !done) begin
            result <= sp_res;
            flags  <= sp_flags;
            done   <= 1'b1;
         end
      end
endmodule

// File: tb/tb_fp_div.sv
// tb_fp_div: randomized and directed checks of fp_div against an arithmetic quotient model
module tb_fp_div;
`ifdef FP_DIV_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif
   logic clk = 1'b0, rst = 1'b1, enable = 1'b1, load = 1'b0;
   logic [31:0] A = '0, B = '0, result;
   logic done, zero, overflow, underflow, NAN, div_by_zero;
   logic [4:0] flags;
   logic [36:0] exp_v = '0, prev_v = '0;
   bit busy = 1'b0, chk_en = 1'b0;
   int n_checks = 0, n_fail = 0;

   fp_div dut (.clk(clk), .rst(rst), .enable(enable), .load(load), .A(A), .B(B), .result(result),
               .done(done), .zero(zero), .overflow(overflow), .underflow(underflow), .NAN(NAN),
               .div_by_zero(div_by_zero));

   assign flags = {zero, overflow, underflow, NAN, div_by_zero};
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, want);
      end
   endtask

   // exact quotient, rounded from the full remainder; returns {result, zero, ovf, unf, nan, dbz}
   function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
      int ea = x[30:23], eb = y[30:23], e, rb;
      bit za = ea == 0, zb = eb == 0;
      bit ia = ea == 255 && x[22:0] == 0, ib = eb == 255 && y[22:0] == 0;
      bit na = ea == 255 && x[22:0] != 0, nb = eb == 255 && y[22:0] != 0;
      logic s = x[31] ^ y[31];
      logic [63:0] num, den, qq, rr, mant, rest, half;
      bit up;
      if (na || nb || (ia && ib) || (za && zb)) return {32'h7FC00000, 5'b00010};
      if (zb && !ia) return {s, 8'hFF, 23'd0, 5'b00001};
      if (ia) return {s, 8'hFF, 23'd0, 5'b00000};
      if (za || ib) return {s, 31'd0, 5'b10000};
      num = 64'({1'b1, x[22:0]}) << 40;
      den = 64'({1'b1, y[22:0]});
      qq = num / den;
      rr = num % den;
      e = ea - eb + 127;
      if (qq >= (64'd1 << 40)) rb = 17;
      else begin
         rb = 16;
         e = e - 1;
      end
      mant = qq >> rb;
      rest = qq & ((64'd1 << rb) - 1);
      half = 64'd1 << (rb - 1);
      up = RND && (rest > half || (rest == half && (rr != 0 || mant[0])));
      if (e <= 0) return {s, 31'd0, 5'b10100};
      mant = mant + 64'(up);
      if (mant[24]) begin
         mant = mant >> 1;
         e = e + 1;
      end
      if (e >= 255) return {s, 8'hFF, 23'd0, 5'b01000};
      return {s, e[7:0], mant[22:0], 5'b00000};
   endfunction

   // outputs must equal the finished result while done is high, and the previous one otherwise
   always @(negedge clk)
      if (chk_en) begin
         if (done) check("out_done", 64'({result, flags}), 64'(exp_v));
         else check("out_hold", 64'({result, flags}), 64'(prev_v));
      end

   task automatic do_reset();
      chk_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      load = 1'b0;
      @(negedge clk);
      check("reset", 64'({result, flags, done}), 64'd0);
      rst = 1'b0;
      exp_v = '0;
      prev_v = '0;
      busy = 1'b0;
      chk_en = 1'b1;
   endtask

   task automatic start(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      A = a;
      B = b;
      load = 1'b1;
      @(posedge clk);
      #1;
      load = 1'b0;
      if (!busy) prev_v = exp_v;
      exp_v = model(a, b);
      busy = 1'b1;
   endtask

   task automatic wait_done(input int lat, input int st_at, input int st_len);
      int cycles = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cycles++;
         if (cycles == st_at) enable = 1'b0;
         if (cycles == st_at + st_len) enable = 1'b1;
         if (done || cycles >= 200) break;
      end
      enable = 1'b1;
      busy = 1'b0;
      check("latency", 64'(cycles), 64'(lat));
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b, input int st_at, input int st_len);
      bit norm = a[30:23] != 0 && a[30:23] != 255 && b[30:23] != 0 && b[30:23] != 255;
      start(a, b);
      wait_done(norm ? 27 + st_len : 1, norm ? st_at : 0, norm ? st_len : 0);
   endtask

   task automatic pin(input string name, input logic [31:0] res, input logic [4:0] flg);
      check(name, 64'({result, flags}), 64'({res, flg}));
   endtask

   function automatic logic [31:0] rnd_op();
      logic [31:0] x = $urandom;
      case ($urandom_range(0, 11))
         0: x[30:23] = 8'd0;
         1: x[30:23] = 8'd255;
         2: x[30:23] = 8'd1;
         3: x[30:23] = 8'd254;
         4, 5, 6: x[30:23] = 8'(120 + $urandom_range(0, 15));
         default: ;
      endcase
      if ($urandom_range(0, 9) == 0) x[22:0] = 23'h7FFFFF;
      return x;
   endfunction

   initial begin
      do_reset();
      op(32'h40C00000, 32'h40000000, 0, 0);
      pin("six_by_two", 32'h40400000, 5'b00000);
      op(32'h3F800000, 32'h40400000, 0, 0);
      pin("one_third", RND ? 32'h3EAAAAAB : 32'h3EAAAAAA, 5'b00000);
      op(32'h7F000000, 32'h3E800000, 0, 0);
      pin("overflow", 32'h7F800000, 5'b01000);
      op(32'h00800000, 32'h40000000, 0, 0);
      pin("underflow", 32'h00000000, 5'b10100);
      op(32'hBF800000, 32'h00000000, 0, 0);
      pin("div_zero", 32'hFF800000, 5'b00001);
      op(32'h00000000, 32'h00000000, 0, 0);
      pin("nan_0_0", 32'h7FC00000, 5'b00010);
      op(32'h7F800000, 32'h7F800000, 0, 0);
      pin("nan_inf_inf", 32'h7FC00000, 5'b00010);
      op(32'h7FC00001, 32'h3F800000, 0, 0);
      pin("nan_in", 32'h7FC00000, 5'b00010);
      op(32'hFF800000, 32'h40000000, 0, 0);
      pin("inf_fin", 32'hFF800000, 5'b00000);
      op(32'h80000000, 32'h3F800000, 0, 0);
      pin("zero_fin", 32'h80000000, 5'b10000);
      op(32'h40C00000, 32'h40000000, 6, 5);
      pin("stall", 32'h40400000, 5'b00000);
      start(32'h40C00000, 32'h40000000);
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      start(32'h3F800000, 32'h40400000);
      wait_done(27, 0, 0);
      pin("abort", RND ? 32'h3EAAAAAB : 32'h3EAAAAAA, 5'b00000);
      start(32'h40C00000, 32'h40000000);
      repeat (8) begin
         @(posedge clk);
         #1;
      end
      do_reset();
      op(32'hC0C00000, 32'h40000000, 0, 0);
      pin("after_reset", 32'hC0400000, 5'b00000);
      for (int i = 0; i < 250; i++) begin
         logic [31:0] a = rnd_op(), b = rnd_op();
         if ($urandom_range(0, 3) == 0) b[22:0] = a[22:0];
         if ($urandom_range(0, 5) == 0) op(a, b, $urandom_range(1, 25), $urandom_range(1, 6));
         else op(a, b, 0, 0);
      end
      @(negedge clk);
      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
